data_mem_bridge: RTL and testbench

DATA_MEM_BRIDGE -- requirements
Module: data_mem_bridge

---
 rtl/mips_mem_pkg.sv | 25 ++
 rtl/bus_timeout_counter.sv | 34 +++
 rtl/data_mem_bridge.sv | 118 +++++++++++
 tb/tb_data_mem_bridge.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the CPU data-memory bridge.
//   state_t             : bridge FSM encoding (IDLE / BUSY / DONE)
//   TIMEOUT_CYCLES_DEF  : default number of BUSY cycles waited for bus_ack
//   ERR_DATA_DEF        : default read data returned on an aborted load
//   word_align()        : clears the byte offset of a CPU address
package mips_mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam int unsigned       TIMEOUT_CYCLES_DEF = 255;
  localparam logic [DATA_W-1:0] ERR_DATA_DEF       = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bus addresses are word-granular; byte lanes are selected by bus_we.
  function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] addr);
    return {addr[DATA_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts BUSY cycles spent waiting for a bus acknowledge.
//   clk, rst   : clock, asynchronous active-low reset
//   clear      : synchronous clear (has priority over enable)
//   enable     : advance the count this cycle
//   expired_c  : combinational, high while enabled on the last permitted cycle
module bus_timeout_counter #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  // Cycle counter; clear wins so a finishing transfer restarts from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  // Flags the cycle whose count equals LIMIT-1, i.e. the LIMIT-th waiting cycle.
  assign expired_c = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/data_mem_bridge.sv
// Bridges the CPU X-stage data-memory port onto a request/ack memory bus.
//   clk, rst            : clock, asynchronous active-low reset
//   en                  : global run enable
//   cpu_en              : combinational CPU enable; low stalls the pipeline
//   cpu_mem_write_en    : per-byte store enables (0 with read_en = load)
//   cpu_mem_read_en     : load request
//   cpu_mem_addr        : byte address
//   cpu_mem_write_data  : store data
//   cpu_mem_read_data   : registered load data, held until the next load completes
//   bus_req/we/addr/wdata : registered bus request, held through BUSY
//   bus_ack, bus_rdata  : one-cycle completion strobe and read data
//   bus_err             : sticky abort flag
module data_mem_bridge
  import mips_mem_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [DATA_W-1:0] ERR_DATA       = ERR_DATA_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              cpu_en,
  input  logic [BE_W-1:0]   cpu_mem_write_en,
  input  logic              cpu_mem_read_en,
  input  logic [DATA_W-1:0] cpu_mem_addr,
  input  logic [DATA_W-1:0] cpu_mem_write_data,
  output logic [DATA_W-1:0] cpu_mem_read_data,
  output logic              bus_req,
  output logic [BE_W-1:0]   bus_we,
  output logic [DATA_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_err
);

  state_t state;
  logic   access;
  logic   tmo_clear;
  logic   tmo_expired;

  assign access    = en && ((|cpu_mem_write_en) || cpu_mem_read_en);
  assign tmo_clear = (state != ST_BUSY) || bus_ack;

  bus_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clear     (tmo_clear),
    .enable    (state == ST_BUSY),
    .expired_c (tmo_expired)
  );

  // CPU stall: the request cycle itself already stalls so the CPU holds its
  // X-stage operands until the transfer completes.
  always_comb begin
    cpu_en = 1'b0;
    case (state)
      ST_IDLE: cpu_en = en && !access;
      ST_BUSY: cpu_en = 1'b0;
      ST_DONE: cpu_en = en;
      default: cpu_en = 1'b0;
    endcase
  end

  // Bridge FSM with registered bus outputs and read-data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= ST_IDLE;
      bus_req           <= 1'b0;
      bus_we            <= '0;
      bus_addr          <= '0;
      bus_wdata         <= '0;
      cpu_mem_read_data <= '0;
      bus_err           <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access) begin
            bus_we    <= cpu_mem_write_en;
            bus_addr  <= word_align(cpu_mem_addr);
            bus_wdata <= cpu_mem_write_data;
            bus_req   <= 1'b1;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Ack is tested first so an ack on the expiry cycle still completes cleanly.
          if (bus_ack) begin
            if (bus_we == '0) begin
              cpu_mem_read_data <= bus_rdata;
            end
            bus_req <= 1'b0;
            state   <= ST_DONE;
          end else if (tmo_expired) begin
            // Stores keep the previous load result; only an aborted load returns ERR_DATA.
            if (bus_we == '0) begin
              cpu_mem_read_data <= ERR_DATA;
            end
            bus_err <= 1'b1;
            bus_req <= 1'b0;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          // The CPU is still presenting the finished request here; never reissue it.
          state <= ST_IDLE;
        end
        default: begin
          bus_req <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed self-checking bench for data_mem_bridge with a read-data scoreboard.
module tb_data_mem_bridge;

  localparam int          TMO = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        cpu_en;
  logic [3:0]  cpu_mem_write_en;
  logic        cpu_mem_read_en;
  logic [31:0] cpu_mem_addr;
  logic [31:0] cpu_mem_write_data;
  logic [31:0] cpu_mem_read_data;
  logic        bus_req;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  logic [31:0] rd_q[$];
  logic [31:0] model_rd;
  logic        model_err;

  data_mem_bridge #(
    .TIMEOUT_CYCLES (TMO),
    .ERR_DATA       (ERR)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .en                 (en),
    .cpu_en             (cpu_en),
    .cpu_mem_write_en   (cpu_mem_write_en),
    .cpu_mem_read_en    (cpu_mem_read_en),
    .cpu_mem_addr       (cpu_mem_addr),
    .cpu_mem_write_data (cpu_mem_write_data),
    .cpu_mem_read_data  (cpu_mem_read_data),
    .bus_req            (bus_req),
    .bus_we             (bus_we),
    .bus_addr           (bus_addr),
    .bus_wdata          (bus_wdata),
    .bus_ack            (bus_ack),
    .bus_rdata          (bus_rdata),
    .bus_err            (bus_err)
  );

  always #5 clk = ~clk;

  always @(posedge bus_req) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Release the CPU port for one cycle.
  task automatic idle();
    cpu_mem_write_en = 4'h0;
    cpu_mem_read_en  = 1'b0;
    en               = 1'b1;
    bus_ack          = 1'b0;
    @(negedge clk);
  endtask

  // One CPU access, called on a negedge while the bridge is IDLE. ack_at is the
  // BUSY cycle index (0-based) carrying bus_ack, or -1 for none. Returns on the
  // negedge of the cycle after DONE with the request still presented.
  task automatic access(input logic [3:0] we, input logic re, input logic [31:0] addr,
                        input logic [31:0] wdata, input int ack_at, input logic [31:0] rdata,
                        input logic drop_en, input string tag);
    logic [31:0] exp_rd;
    int          n;
    int          exp_n;
    bit          acked;
    acked = (ack_at >= 0) && (ack_at < TMO);
    exp_n = acked ? ack_at + 1 : TMO;
    if (we == 4'h0) exp_rd = acked ? rdata : ERR;
    else            exp_rd = model_rd;
    if (!acked) model_err = 1'b1;
    model_rd = exp_rd;
    rd_q.push_back(exp_rd);

    en                 = 1'b1;
    cpu_mem_write_en   = we;
    cpu_mem_read_en    = re;
    cpu_mem_addr       = addr;
    cpu_mem_write_data = wdata;
    #1 chk({tag, "_cpu_en_req"}, 32'(cpu_en), 32'(1'b0));
    @(negedge clk);
    chk({tag, "_bus_addr"},  bus_addr,        addr & 32'hFFFF_FFFC);
    chk({tag, "_bus_we"},    32'(bus_we),     32'(we));
    chk({tag, "_bus_wdata"}, bus_wdata,       wdata);
    n = 0;
    while (bus_req === 1'b1 && n < 20) begin
      chk({tag, "_cpu_en_busy"}, 32'(cpu_en), 32'(1'b0));
      if (drop_en) en = 1'b0;
      bus_ack   = (n == ack_at);
      bus_rdata = (n == ack_at) ? rdata : 32'h0BAD_0BAD;
      @(negedge clk);
      bus_ack = 1'b0;
      n++;
    end
    chk({tag, "_req_cycles"}, 32'(n), 32'(exp_n));
    chk({tag, "_cpu_en_done"}, 32'(cpu_en), 32'(!drop_en));
    @(negedge clk);
    chk({tag, "_no_reissue"}, 32'(bus_req), 32'(1'b0));
    chk({tag, "_rdata"}, cpu_mem_read_data, rd_q.pop_front());
    chk({tag, "_bus_err"}, 32'(bus_err), 32'(model_err));
  endtask

  initial begin
    int p0;
    rst                = 1'b0;
    en                 = 1'b1;
    cpu_mem_write_en   = 4'h0;
    cpu_mem_read_en    = 1'b0;
    cpu_mem_addr       = 32'h0;
    cpu_mem_write_data = 32'h0;
    bus_ack            = 1'b0;
    bus_rdata          = 32'h0;
    model_rd           = 32'h0;
    model_err          = 1'b0;

    // Reset state
    #1;
    chk("rst_bus_req",  32'(bus_req),  32'(1'b0));
    chk("rst_bus_we",   32'(bus_we),   32'h0);
    chk("rst_bus_addr", bus_addr,      32'h0);
    chk("rst_rdata",    cpu_mem_read_data, 32'h0);
    chk("rst_bus_err",  32'(bus_err),  32'(1'b0));
    chk("rst_cpu_en",   32'(cpu_en),   32'(1'b1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Load, misaligned address, ack in second BUSY cycle
    access(4'h0, 1'b1, 32'h0000_1006, 32'h0, 1, 32'h1122_3344, 1'b0, "ld_basic");
    idle();

    // Byte store leaves read register untouched
    access(4'b0010, 1'b0, 32'h0000_2001, 32'hABAB_ABAB, 0, 32'h9999_9999, 1'b0, "st_byte");
    idle();

    // Ack on the expiry cycle wins over timeout
    access(4'h0, 1'b1, 32'h0000_0040, 32'h0, TMO - 1, 32'h0000_0005, 1'b0, "ld_ack_expiry");
    idle();

    // en dropped mid-transfer: transfer completes, CPU stays stalled
    access(4'h0, 1'b1, 32'h0000_0080, 32'h0, 2, 32'h7777_0000, 1'b1, "ld_en_drop");
    idle();

    // Back-to-back zero-wait loads
    p0 = pulses;
    access(4'h0, 1'b1, 32'h0000_0100, 32'h0, 0, 32'hA1A1_0001, 1'b0, "b2b_first");
    access(4'h0, 1'b1, 32'h0000_0104, 32'h0, 0, 32'hB2B2_0002, 1'b0, "b2b_second");
    idle();
    chk("b2b_pulses", 32'(pulses - p0), 32'd2);

    // Load with no ack: abort after TMO cycles
    access(4'h0, 1'b1, 32'h0000_0200, 32'h0, -1, 32'h0, 1'b0, "ld_timeout");
    idle();
    chk("timeout_cpu_resumes", 32'(cpu_en), 32'(1'b1));

    // Reset in BUSY, then a stray ack
    en                 = 1'b1;
    cpu_mem_write_en   = 4'hF;
    cpu_mem_addr       = 32'h0000_3000;
    cpu_mem_write_data = 32'h5555_AAAA;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy_req", 32'(bus_req), 32'(1'b1));
    rst = 1'b0;
    #1;
    chk("arst_bus_req",   32'(bus_req),  32'(1'b0));
    chk("arst_bus_we",    32'(bus_we),   32'h0);
    chk("arst_bus_addr",  bus_addr,      32'h0);
    chk("arst_bus_wdata", bus_wdata,     32'h0);
    chk("arst_rdata",     cpu_mem_read_data, 32'h0);
    chk("arst_bus_err",   32'(bus_err),  32'(1'b0));
    cpu_mem_write_en = 4'h0;
    #1 chk("arst_cpu_en", 32'(cpu_en), 32'(1'b1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("stray_ack_req",   32'(bus_req), 32'(1'b0));
    chk("stray_ack_rdata", cpu_mem_read_data, 32'h0);
    chk("stray_ack_cpu_en", 32'(cpu_en), 32'(1'b1));
    @(negedge clk);
    chk("stray_ack_idle_req", 32'(bus_req), 32'(1'b0));
    chk("stray_ack_rdata2",   cpu_mem_read_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
